// File: rtl/hack_cpu_dbg.sv
// Parametrised Hack CPU core with halt/step/resume run-control and a retired-instruction counter.
// Define HACK_DBG_BREAKPOINT_EN to enable the hardware PC breakpoint and dbg_bp_hit.
module hack_cpu_dbg #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 15,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [WIDTH-1:0]  inM,
  output logic [WIDTH-1:0]  outM,
  output logic [ADDR_W-1:0] addressM,
  output logic              writeM,
  output logic [PC_W-1:0]   pc,
  input  logic              dbg_halt_req,
  input  logic              dbg_resume,
  input  logic              dbg_step,
  input  logic              dbg_bp_en,
  input  logic [PC_W-1:0]   dbg_bp_addr,
  output logic              dbg_halted,
  output logic              dbg_bp_hit,
  output logic [CNT_W-1:0]  dbg_retired
);

  typedef enum logic {HALT_RUN = 1'b0, HALT_STOP = 1'b1} halt_state_t;

  halt_state_t      halt_state, halt_next;
  logic [WIDTH-1:0] a_reg, d_reg;
  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic             is_c, exec, bp_match, jump, alu_zr, alu_ng;

`ifdef HACK_DBG_BREAKPOINT_EN
  assign bp_match = dbg_bp_en && (pc == dbg_bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{dbg_bp_en, dbg_bp_addr};
  assign bp_match  = 1'b0;
`endif

  assign is_c       = instruction[15];
  assign dbg_halted = (halt_state == HALT_STOP);
  // A halted core only moves on a step pulse, and a step deliberately ignores the breakpoint.
  assign exec       = dbg_halted ? dbg_step : !bp_match;

  always_comb begin
    alu_x = d_reg;
    alu_y = instruction[12] ? inM : a_reg;
    if (instruction[11]) alu_x = '0;
    if (instruction[10]) alu_x = ~alu_x;
    if (instruction[9])  alu_y = '0;
    if (instruction[8])  alu_y = ~alu_y;
    alu_out = instruction[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (instruction[6])  alu_out = ~alu_out;
  end

  assign alu_zr   = (alu_out == '0);
  assign alu_ng   = alu_out[WIDTH-1];
  assign jump     = (instruction[2] && alu_ng) || (instruction[1] && alu_zr) ||
                    (instruction[0] && !alu_ng && !alu_zr);
  assign outM     = alu_out;
  assign addressM = a_reg[ADDR_W-1:0];
  assign writeM   = exec && is_c && instruction[3];

  // Jump target and store address both use A as it was before this instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg       <= '0;
      d_reg       <= '0;
      pc          <= '0;
      dbg_retired <= '0;
    end else if (exec) begin
      if (!is_c) begin
        a_reg <= {{(WIDTH-15){1'b0}}, instruction[14:0]};
      end else begin
        if (instruction[5]) a_reg <= alu_out;
        if (instruction[4]) d_reg <= alu_out;
      end
      pc          <= (is_c && jump) ? a_reg[PC_W-1:0] : pc + PC_W'(1);
      dbg_retired <= dbg_retired + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halt_state <= HALT_RUN;
    else        halt_state <= halt_next;
  end

  always_comb begin
    halt_next = halt_state;
    if (dbg_halt_req)
      halt_next = HALT_STOP;
    else if (halt_state == HALT_RUN && bp_match)
      halt_next = HALT_STOP;
    else if (dbg_resume)
      halt_next = HALT_RUN;
  end

`ifdef HACK_DBG_BREAKPOINT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dbg_bp_hit <= 1'b0;
    else if (halt_next == HALT_RUN)
      dbg_bp_hit <= 1'b0;
    else if (halt_state == HALT_RUN && bp_match)
      dbg_bp_hit <= 1'b1;
  end
`else
  assign dbg_bp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_dbg.sv
// Directed bench for hack_cpu_dbg: a 16-bit core on a small ROM program plus a 32-bit core
// running a negate sequence, both sharing clock, reset and debug controls.
module tb_hack_cpu_dbg;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbg_halt_req, dbg_resume, dbg_step, dbg_bp_en;
  logic [14:0] dbg_bp_addr;

  logic [15:0] rom [0:63];
  logic [15:0] instruction;
  logic [15:0] inM, outM;
  logic [14:0] addressM, pc;
  logic        writeM, dbg_halted, dbg_bp_hit;
  logic [31:0] dbg_retired;

  logic [15:0] rom32 [0:7];
  logic [15:0] instruction32;
  logic [31:0] inM32, outM32;
  logic [14:0] addressM32, pc32;
  logic        writeM32, halted32, bp_hit32;
  logic [31:0] retired32;

  int compared   = 0;
  int mismatched = 0;

  assign instruction   = rom[pc[5:0]];
  assign instruction32 = rom32[pc32[2:0]];

  hack_cpu_dbg dut (
    .clk(clk), .reset(reset), .instruction(instruction), .inM(inM), .outM(outM),
    .addressM(addressM), .writeM(writeM), .pc(pc),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
    .dbg_bp_en(dbg_bp_en), .dbg_bp_addr(dbg_bp_addr),
    .dbg_halted(dbg_halted), .dbg_bp_hit(dbg_bp_hit), .dbg_retired(dbg_retired)
  );

  hack_cpu_dbg #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .instruction(instruction32), .inM(inM32), .outM(outM32),
    .addressM(addressM32), .writeM(writeM32), .pc(pc32),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume), .dbg_step(dbg_step),
    .dbg_bp_en(dbg_bp_en), .dbg_bp_addr(dbg_bp_addr),
    .dbg_halted(halted32), .dbg_bp_hit(bp_hit32), .dbg_retired(retired32)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'hEA87;
    rom[0]  = 16'h2345; rom[1]  = 16'hEC10; rom[2]  = 16'h1234; rom[3]  = 16'hE088;
    rom[4]  = 16'hE4C8; rom[5]  = 16'hE1C8; rom[6]  = 16'hE008; rom[7]  = 16'hE548;
    rom[8]  = 16'h0010; rom[9]  = 16'hEA87;
    rom[16] = 16'hE7D0; rom[17] = 16'h002E; rom[18] = 16'hEA87;
    rom[46] = 16'hEE90; rom[47] = 16'h0033; rom[48] = 16'hE304;
    rom[51] = 16'hEFD0; rom[52] = 16'h0037; rom[53] = 16'hE304; rom[54] = 16'hE301;
    rom[55] = 16'hE302; rom[56] = 16'hFC10; rom[57] = 16'hF088; rom[58] = 16'h003A;
    rom[59] = 16'hEA87;
    rom32[0] = 16'h7FFF; rom32[1] = 16'hEC10; rom32[2] = 16'hE090; rom32[3] = 16'hE3D0;
    rom32[4] = 16'hE308; rom32[5] = 16'h0005; rom32[6] = 16'hEA87; rom32[7] = 16'hEA87;

    reset = 1'b0; dbg_halt_req = 1'b0; dbg_resume = 1'b0; dbg_step = 1'b0;
    dbg_bp_en = 1'b0; dbg_bp_addr = 15'h0; inM = 16'h0042; inM32 = 32'h0;
    applyStimulus(2);

    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_halted", dbg_halted, 0);
    checkOutput("rst_bp_hit", dbg_bp_hit, 0);
    checkOutput("rst_retired", dbg_retired, 0);
    checkOutput("rst_writeM", writeM, 0);
    checkOutput("rst_outM", outM, 32'hFFFF);
    checkOutput("rst_addressM", addressM, 0);
    checkOutput("rst32_outM", outM32, 32'h0000_0001);
    checkOutput("rst32_pc", pc32, 0);
    checkOutput("rst32_halted", halted32, 0);
    checkOutput("rst32_bp_hit", bp_hit32, 0);

    reset = 1'b1;
    applyStimulus(3);
    checkOutput("add_pc", pc, 3);
    checkOutput("add_outM", outM, 32'h3579);
    checkOutput("add_addressM", addressM, 32'h1234);
    checkOutput("add_writeM", writeM, 1);
    applyStimulus(1);
    checkOutput("add_retired", dbg_retired, 4);
    checkOutput("sub_outM", outM, 32'h1111);
    checkOutput("sub_writeM", writeM, 1);
    checkOutput("w32_outM", outM32, 32'hFFFF_0002);
    checkOutput("w32_writeM", writeM32, 1);
    checkOutput("w32_addressM", addressM32, 32'h7FFF);
    checkOutput("w32_retired", retired32, 4);
    applyStimulus(1);
    checkOutput("rsub_outM", outM, 32'hEEEF);
    applyStimulus(1);
    checkOutput("and_outM", outM, 32'h0204);
    applyStimulus(1);
    checkOutput("or_outM", outM, 32'h3375);
    checkOutput("or_writeM", writeM, 1);
    applyStimulus(1);
    checkOutput("ainst_writeM", writeM, 0);
    applyStimulus(2);
    checkOutput("jmp_pc", pc, 32'h10);
    applyStimulus(5);
    checkOutput("jlt_at_pc", pc, 32'h30);
    checkOutput("jlt_outM", outM, 32'hFFFF);
    applyStimulus(1);
    checkOutput("jlt_taken_pc", pc, 32'h33);
    applyStimulus(3);
    checkOutput("jlt_not_taken_pc", pc, 32'h36);
    applyStimulus(1);
    checkOutput("jgt_taken_pc", pc, 32'h37);
    applyStimulus(1);
    checkOutput("jeq_not_taken_pc", pc, 32'h38);
    checkOutput("run_retired", dbg_retired, 21);
    checkOutput("dm_outM", outM, 32'h0042);
    applyStimulus(1);
    checkOutput("dpm_outM", outM, 32'h0084);
    checkOutput("dpm_addressM", addressM, 32'h0037);
    checkOutput("dpm_writeM", writeM, 1);

    reset = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(3);
    checkOutput("pre_reset_writeM", writeM, 1);
    reset = 1'b0;
    #2;
    checkOutput("async_rst_pc", pc, 0);
    checkOutput("async_rst_writeM", writeM, 0);
    checkOutput("async_rst_retired", dbg_retired, 0);
    checkOutput("async_rst_addressM", addressM, 0);
    applyStimulus(1);
    reset = 1'b1;

    applyStimulus(5);
    dbg_halt_req = 1'b1;
    applyStimulus(1);
    dbg_halt_req = 1'b0;
    checkOutput("halt_pc", pc, 6);
    checkOutput("halt_halted", dbg_halted, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("halt_writeM", writeM, 0);
    end
    checkOutput("halt_pc_hold", pc, 6);
    checkOutput("halt_retired_hold", dbg_retired, 6);
    dbg_step = 1'b1;
    #1;
    checkOutput("step_writeM", writeM, 1);
    checkOutput("step_outM", outM, 32'h0204);
    applyStimulus(1);
    dbg_step = 1'b0;
    checkOutput("step_pc", pc, 7);
    checkOutput("step_retired", dbg_retired, 7);
    checkOutput("step_halted", dbg_halted, 1);
    dbg_resume = 1'b1;
    applyStimulus(1);
    dbg_resume = 1'b0;
    checkOutput("resume_halted", dbg_halted, 0);
    checkOutput("resume_pc", pc, 7);
    applyStimulus(1);
    checkOutput("resume_run_pc", pc, 8);
    checkOutput("resume_run_retired", dbg_retired, 8);

    reset = 1'b0;
    applyStimulus(1);
    dbg_bp_en = 1'b1;
    dbg_bp_addr = 15'h0010;
    reset = 1'b1;
    applyStimulus(10);
    checkOutput("bp_reach_pc", pc, 32'h10);
    checkOutput("bp_reach_retired", dbg_retired, 10);
`ifdef HACK_DBG_BREAKPOINT_EN
    checkOutput("bp_pre_halted", dbg_halted, 0);
    applyStimulus(1);
    checkOutput("bp_pc", pc, 32'h10);
    checkOutput("bp_halted", dbg_halted, 1);
    checkOutput("bp_hit", dbg_bp_hit, 1);
    checkOutput("bp_retired", dbg_retired, 10);
    dbg_step = 1'b1;
    applyStimulus(1);
    dbg_step = 1'b0;
    checkOutput("bp_step_pc", pc, 32'h11);
    checkOutput("bp_step_halted", dbg_halted, 1);
    checkOutput("bp_step_hit", dbg_bp_hit, 1);
    dbg_resume = 1'b1;
    applyStimulus(1);
    dbg_resume = 1'b0;
    checkOutput("bp_resume_halted", dbg_halted, 0);
    checkOutput("bp_resume_hit", dbg_bp_hit, 0);
    applyStimulus(1);
    checkOutput("bp_resume_pc", pc, 32'h12);
`else
    applyStimulus(1);
    checkOutput("nobp_pc", pc, 32'h11);
    checkOutput("nobp_halted", dbg_halted, 0);
    checkOutput("nobp_hit", dbg_bp_hit, 0);
    checkOutput("nobp_retired", dbg_retired, 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
